// File: rtl/fft_pkg.sv
// Shared types and helpers for the FFT post-processing blocks: the complex
// sample layout, the averaging FSM encoding and the power helper.
package fft_pkg;

  localparam int unsigned PKG_DATA_WIDTH = 16;

  typedef struct packed {
    logic signed [PKG_DATA_WIDTH-1:0] re;
    logic signed [PKG_DATA_WIDTH-1:0] im;
  } complex_t;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    ACCUM = 2'd1,
    EMIT  = 2'd2
  } pavg_state_e;

  // re^2 + im^2 never exceeds 2^(2*DW-1), so the unsigned sum cannot wrap.
  function automatic logic [2*PKG_DATA_WIDTH-1:0] power(input complex_t c);
    logic signed [2*PKG_DATA_WIDTH-1:0] re_sq;
    logic signed [2*PKG_DATA_WIDTH-1:0] im_sq;
    re_sq = (2*PKG_DATA_WIDTH)'(c.re) * (2*PKG_DATA_WIDTH)'(c.re);
    im_sq = (2*PKG_DATA_WIDTH)'(c.im) * (2*PKG_DATA_WIDTH)'(c.im);
    return $unsigned(re_sq) + $unsigned(im_sq);
  endfunction

endpackage

// File: rtl/pavg_out_fifo.sv
// Two-entry valid/ready output FIFO carrying {power, bin, last}; the head
// entry drives the outputs straight from registers.
module pavg_out_fifo #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned BIN_W  = 10
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              i_push,
  input  logic [DATA_W-1:0] i_data,
  input  logic [BIN_W-1:0]  i_bin,
  input  logic              i_last,
  input  logic              i_ready,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data,
  output logic [BIN_W-1:0]  o_bin,
  output logic              o_last,
  output logic [1:0]        o_occ
);

  localparam int unsigned ENT_W = DATA_W + BIN_W + 1;

  logic [ENT_W-1:0] r_head;
  logic [ENT_W-1:0] r_tail;
  logic [1:0]       r_occ;
  logic [ENT_W-1:0] w_in;
  logic             w_pop;

  assign w_in  = {i_data, i_bin, i_last};
  assign w_pop = (r_occ != 2'd0) && i_ready;

  // Head/tail entries and occupancy; upstream credit keeps a push off a full FIFO.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_head <= '0;
      r_tail <= '0;
      r_occ  <= 2'd0;
    end else begin
      case ({i_push, w_pop})
        2'b10: begin
          if (r_occ == 2'd0) begin
            r_head <= w_in;
            r_occ  <= 2'd1;
          end else if (r_occ == 2'd1) begin
            r_tail <= w_in;
            r_occ  <= 2'd2;
          end
        end
        2'b01: begin
          r_head <= r_tail;
          r_occ  <= r_occ - 2'd1;
        end
        2'b11: begin
          if (r_occ == 2'd1) begin
            r_head <= w_in;
          end else begin
            r_head <= r_tail;
            r_tail <= w_in;
          end
        end
        default: begin
          r_occ <= r_occ;
        end
      endcase
    end
  end

  assign o_valid = (r_occ != 2'd0);
  assign o_data  = r_head[ENT_W-1 -: DATA_W];
  assign o_bin   = r_head[BIN_W:1];
  assign o_last  = r_head[0];
  assign o_occ   = r_occ;

endmodule

// File: rtl/prim_ram.sv
// Simple dual-port RAM primitive: one write port, one read port with a
// registered (one-cycle) read.
module prim_ram #(
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned WIDTH = 34,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_re,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rdata;

  // Storage array, write port.
  always_ff @(posedge clk_i) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Registered read port.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rdata <= '0;
    end else if (i_re) begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/fft_power_avg.sv
// Per-bin power of the FFT output stream, averaged over 2^LOG2_NUM_AVG frames
// and emitted as one spectrum per averaging period over valid/ready.
module fft_power_avg
  import fft_pkg::*;
#(
  parameter int unsigned FFT_SIZE     = 1024,
  parameter int unsigned DATA_WIDTH   = 16,
  parameter int unsigned LOG2_NUM_AVG = 2,
  parameter int unsigned OUT_WIDTH    = 2 * DATA_WIDTH,
  localparam int unsigned BIN_W       = $clog2(FFT_SIZE)
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    in_valid_i,
  input  logic [2*DATA_WIDTH-1:0] in_data_i,
  output logic                    in_ready_o,
  output logic                    out_valid_o,
  output logic [OUT_WIDTH-1:0]    out_data_o,
  output logic [BIN_W-1:0]        out_bin_o,
  output logic                    out_last_o,
  input  logic                    out_ready_i,
  output logic                    frame_done_o
);

  localparam int unsigned ACC_W       = OUT_WIDTH + LOG2_NUM_AVG;
  localparam int unsigned FC_W        = (LOG2_NUM_AVG > 0) ? LOG2_NUM_AVG : 1;
  localparam int          NUM_AVG     = 1 << LOG2_NUM_AVG;
  localparam logic [BIN_W-1:0] LAST_BIN = BIN_W'(FFT_SIZE - 1);
  localparam pavg_state_e RESET_STATE = pavg_state_e'((LOG2_NUM_AVG == 0) ? EMIT : FILL);

  logic [BIN_W-1:0]     r_bin_cnt;
  logic [FC_W-1:0]      r_frame_cnt;
  pavg_state_e          r_state;
  pavg_state_e          w_state_nxt;
  logic                 w_accept;
  logic                 w_wrap;
  logic [OUT_WIDTH-1:0] w_power;

  logic                 r_s1_valid;
  logic [OUT_WIDTH-1:0] r_s1_power;
  logic [BIN_W-1:0]     r_s1_bin;
  pavg_state_e          r_s1_state;
  logic [ACC_W-1:0]     w_rdata;
  logic [ACC_W-1:0]     w_sum;
  logic [OUT_WIDTH-1:0] w_avg;
  logic                 w_s1_push;
  logic                 w_acc_we;

  logic [1:0]           w_occ;
  logic                 w_pop;
  logic [2:0]           w_credit;
  logic                 r_frame_done;

  assign w_accept  = in_valid_i && in_ready_o;
  assign w_wrap    = w_accept && (r_bin_cnt == LAST_BIN);
  assign w_pop     = out_valid_o && out_ready_i;
  assign w_s1_push = r_s1_valid && (r_s1_state == EMIT);
  assign w_acc_we  = r_s1_valid && (r_s1_state != EMIT);

  if (DATA_WIDTH == PKG_DATA_WIDTH) begin : g_pkg_power
    complex_t w_cplx;
    assign w_cplx  = in_data_i;
    assign w_power = OUT_WIDTH'(power(w_cplx));
  end else begin : g_gen_power
    logic signed [DATA_WIDTH-1:0]   w_re;
    logic signed [DATA_WIDTH-1:0]   w_im;
    logic signed [2*DATA_WIDTH-1:0] w_re_sq;
    logic signed [2*DATA_WIDTH-1:0] w_im_sq;
    assign w_re    = in_data_i[2*DATA_WIDTH-1:DATA_WIDTH];
    assign w_im    = in_data_i[DATA_WIDTH-1:0];
    assign w_re_sq = (2*DATA_WIDTH)'(w_re) * (2*DATA_WIDTH)'(w_re);
    assign w_im_sq = (2*DATA_WIDTH)'(w_im) * (2*DATA_WIDTH)'(w_im);
    assign w_power = OUT_WIDTH'($unsigned(w_re_sq) + $unsigned(w_im_sq));
  end

  // Averaging FSM advances only on the accept of the last bin of a frame.
  always_comb begin
    w_state_nxt = r_state;
    if (w_wrap) begin
      case (r_state)
        FILL: begin
          if (NUM_AVG == 2) w_state_nxt = EMIT;
          else              w_state_nxt = ACCUM;
        end
        ACCUM: begin
          if (r_frame_cnt == FC_W'(NUM_AVG - 2)) w_state_nxt = EMIT;
          else                                   w_state_nxt = ACCUM;
        end
        EMIT: begin
          if (LOG2_NUM_AVG == 0) w_state_nxt = EMIT;
          else                   w_state_nxt = FILL;
        end
        default: w_state_nxt = RESET_STATE;
      endcase
    end else begin
      w_state_nxt = r_state;
    end
  end

  // Bin/frame counters and FSM state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_bin_cnt   <= '0;
      r_frame_cnt <= '0;
      r_state     <= RESET_STATE;
    end else if (w_accept) begin
      r_bin_cnt <= r_bin_cnt + BIN_W'(1);
      if (w_wrap) begin
        r_frame_cnt <= r_frame_cnt + FC_W'(1);
      end
      r_state <= w_state_nxt;
    end
  end

  // s1 stage: power, bin and the mode the beat was accepted in.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_s1_valid <= 1'b0;
      r_s1_power <= '0;
      r_s1_bin   <= '0;
      r_s1_state <= RESET_STATE;
    end else begin
      r_s1_valid <= w_accept;
      if (w_accept) begin
        r_s1_power <= w_power;
        r_s1_bin   <= r_bin_cnt;
        r_s1_state <= r_state;
      end
    end
  end

  // Read is issued on accept so the old sum lines up with s1.
  prim_ram #(
    .DEPTH (FFT_SIZE),
    .WIDTH (ACC_W)
  ) u_acc_ram (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .i_we    (w_acc_we),
    .i_waddr (r_s1_bin),
    .i_wdata (w_sum),
    .i_re    (w_accept),
    .i_raddr (r_bin_cnt),
    .o_rdata (w_rdata)
  );

  // FILL discards the stale accumulator; the other modes add to it.
  always_comb begin
    w_sum = ACC_W'(r_s1_power);
    case (r_s1_state)
      FILL:        w_sum = ACC_W'(r_s1_power);
      ACCUM, EMIT: w_sum = w_rdata + ACC_W'(r_s1_power);
      default:     w_sum = ACC_W'(r_s1_power);
    endcase
  end

  assign w_avg = OUT_WIDTH'(w_sum >> LOG2_NUM_AVG);

  pavg_out_fifo #(
    .DATA_W (OUT_WIDTH),
    .BIN_W  (BIN_W)
  ) u_out_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .i_push  (w_s1_push),
    .i_data  (w_avg),
    .i_bin   (r_s1_bin),
    .i_last  (r_s1_bin == LAST_BIN),
    .i_ready (out_ready_i),
    .o_valid (out_valid_o),
    .o_data  (out_data_o),
    .o_bin   (out_bin_o),
    .o_last  (out_last_o),
    .o_occ   (w_occ)
  );

  // An EMIT beat may only enter if its push will still find a free entry.
  always_comb begin
    w_credit = {1'b0, w_occ} + {2'b00, w_s1_push} - {2'b00, w_pop};
    if (r_state == EMIT) begin
      in_ready_o = (w_credit < 3'd2);
    end else begin
      in_ready_o = 1'b1;
    end
  end

  // Pulse after the last bin of a spectrum leaves the FIFO.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= w_pop && out_last_o;
    end
  end

  assign frame_done_o = r_frame_done;

endmodule

// File: tb/tb_fft_power_avg.sv
// Bench for fft_power_avg: directed and random frames checked against a
// frame-history averaging model, plus a pass-through (no averaging) instance.
module tb_fft_power_avg;

  localparam int FFT   = 1024;
  localparam int L     = 2;
  localparam int NAVG  = 4;
  localparam int FFT_B = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_last, out_ready, frame_done;
  logic [31:0] in_data, out_data;
  logic [9:0]  out_bin;
  logic        b_in_valid, b_in_ready, b_out_valid, b_out_last, b_out_ready, b_frame_done;
  logic [31:0] b_in_data, b_out_data;
  logic [2:0]  b_out_bin;

  typedef struct { logic [31:0] data; logic [9:0] bin; logic last; } exp_t;
  typedef struct { logic [31:0] data; logic [2:0] bin; int cyc; } expb_t;

  int     n_tests = 0;
  int     n_fail  = 0;
  int     cyc     = 0;
  bit     mon_en  = 1'b0;
  bit     rnd_ready = 1'b0;
  int     gap_pct = 0;
  exp_t   exp_q[$];
  expb_t  expb_q[$];
  longint m_pow [NAVG][FFT];
  int     m_frame = 0;
  int     m_bin   = 0;
  int     mb_bin  = 0;
  bit     exp_fd  = 1'b0;
  bit     expb_fd = 1'b0;
  bit     fd_next, fdb_next;
  exp_t   mon_e;
  expb_t  monb_e;

  fft_power_avg #(.FFT_SIZE(FFT), .DATA_WIDTH(16), .LOG2_NUM_AVG(L), .OUT_WIDTH(32)) dut (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_data_i(in_data),
    .in_ready_o(in_ready), .out_valid_o(out_valid), .out_data_o(out_data),
    .out_bin_o(out_bin), .out_last_o(out_last), .out_ready_i(out_ready),
    .frame_done_o(frame_done));

  fft_power_avg #(.FFT_SIZE(FFT_B), .DATA_WIDTH(16), .LOG2_NUM_AVG(0), .OUT_WIDTH(32)) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(b_in_valid), .in_data_i(b_in_data),
    .in_ready_o(b_in_ready), .out_valid_o(b_out_valid), .out_data_o(b_out_data),
    .out_bin_o(b_out_bin), .out_last_o(b_out_last), .out_ready_i(b_out_ready),
    .frame_done_o(b_frame_done));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int rnd16();
    return int'($signed(16'($urandom)));
  endfunction

  // Model: remember every frame's power per bin; the last frame of each
  // averaging period yields floor(sum / NAVG) for that bin.
  function automatic void model_accept(input int re, input int im);
    longint s;
    exp_t   e;
    m_pow[m_frame][m_bin] = longint'(re) * longint'(re) + longint'(im) * longint'(im);
    if (m_frame == NAVG - 1) begin
      s = 0;
      for (int k = 0; k < NAVG; k++) s += m_pow[k][m_bin];
      e.data = 32'(s / NAVG);
      e.bin  = 10'(m_bin);
      e.last = (m_bin == FFT - 1);
      exp_q.push_back(e);
    end
    m_bin++;
    if (m_bin == FFT) begin
      m_bin   = 0;
      m_frame = (m_frame + 1) % NAVG;
    end
  endfunction

  task automatic send(input int re, input int im);
    int waits;
    bit ok;
    waits = 0;
    ok    = 1'b0;
    if (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) begin
      in_valid  = 1'b0;
      out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
    end
    in_valid = 1'b1;
    in_data  = {16'(re), 16'(im)};
    while (!ok && waits < 64) begin
      out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (in_ready) ok = 1'b1;
      else begin
        waits++;
        @(negedge clk);
      end
    end
    if (!ok) check("in_ready_timeout", in_ready, 1'b1);
    else     model_accept(re, im);
    @(negedge clk);
  endtask

  task automatic sendb(input int re, input int im);
    expb_t e;
    b_in_valid = 1'b1;
    b_in_data  = {16'(re), 16'(im)};
    #1;
    if (b_in_ready) begin
      e.data = 32'(longint'(re) * re + longint'(im) * im);
      e.bin  = 3'(mb_bin);
      e.cyc  = cyc;
      expb_q.push_back(e);
      mb_bin = (mb_bin + 1) % FFT_B;
    end else begin
      check("b_in_ready", b_in_ready, 1'b1);
    end
    @(negedge clk);
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 16 && exp_q.size() != 0; i++) @(negedge clk);
    repeat (2) @(negedge clk);
    check("all_outputs_seen", exp_q.size(), 0);
  endtask

  task automatic do_reset();
    mon_en     = 1'b0;
    in_valid   = 1'b0;
    b_in_valid = 1'b0;
    out_ready  = 1'b1;
    rst_n      = 1'b0;
    repeat (3) @(negedge clk);
    rst_n   = 1'b1;
    m_frame = 0;
    m_bin   = 0;
    mb_bin  = 0;
    exp_q.delete();
    expb_q.delete();
    exp_fd  = 1'b0;
    expb_fd = 1'b0;
    @(negedge clk);
    #1;
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_data", out_data, 32'd0);
    check("rst_out_bin", out_bin, 10'd0);
    check("rst_out_last", out_last, 1'b0);
    check("rst_frame_done", frame_done, 1'b0);
    check("rst_b_in_ready", b_in_ready, 1'b1);
    check("rst_b_out_valid", b_out_valid, 1'b0);
    mon_en = 1'b1;
    @(negedge clk);
  endtask

  // Scoreboard for the averaging instance; a transfer is decided in the
  // cycle it is observed here and lands on the following rising edge.
  always @(negedge clk) begin
    #2;
    if (mon_en) begin
      fd_next = 1'b0;
      check("frame_done", frame_done, exp_fd);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("spurious_out_valid", out_valid, 1'b0);
        end else begin
          mon_e = exp_q.pop_front();
          check("out_data", out_data, mon_e.data);
          check("out_bin", out_bin, mon_e.bin);
          check("out_last", out_last, mon_e.last);
          fd_next = mon_e.last;
        end
      end
      exp_fd = fd_next;
    end
  end

  // Scoreboard for the pass-through instance, including accept-to-valid latency.
  always @(negedge clk) begin
    #2;
    if (mon_en) begin
      fdb_next = 1'b0;
      check("b_frame_done", b_frame_done, expb_fd);
      if (b_out_valid) begin
        if (expb_q.size() == 0) begin
          check("b_spurious_out_valid", b_out_valid, 1'b0);
        end else begin
          monb_e = expb_q.pop_front();
          check("b_out_data", b_out_data, monb_e.data);
          check("b_out_bin", b_out_bin, monb_e.bin);
          check("b_out_last", b_out_last, monb_e.bin == 3'd7);
          check("b_latency", 64'(cyc - monb_e.cyc), 64'd2);
          fdb_next = (monb_e.bin == 3'd7);
        end
      end
      expb_fd = fdb_next;
    end
  end

  initial begin
    rst_n       = 1'b0;
    in_valid    = 1'b0;
    in_data     = 32'd0;
    out_ready   = 1'b1;
    b_in_valid  = 1'b0;
    b_in_data   = 32'd0;
    b_out_ready = 1'b1;
    @(negedge clk);
    do_reset();

    // Constant tone: 100^2 on every bin, output only in the fourth frame.
    repeat (NAVG * FFT) send(100, 0);
    drain();

    // re = 1,2,3,4 per frame: floor(30/4) = 7, with random input bubbles.
    gap_pct = 10;
    for (int f = 0; f < NAVG; f++) repeat (FFT) send(f + 1, 0);
    drain();
    gap_pct = 0;

    // Full-scale negative corner: 2 * 2^30 averaged stays 0x80000000.
    repeat (NAVG * FFT) send(-32768, -32768);
    drain();

    // Random data with random downstream backpressure.
    rnd_ready = 1'b1;
    repeat (NAVG * FFT) send(rnd16(), rnd16());
    rnd_ready = 1'b0;
    drain();

    // Reset at bin 500 of frame 2, then four clean frames of re = 3.
    repeat (2 * FFT + 500) send(rnd16(), rnd16());
    do_reset();
    repeat (NAVG * FFT) send(3, 0);
    drain();

    // Pass-through instance: 3+4j gives 25, then random samples.
    for (int i = 0; i < 2 * FFT_B; i++) sendb(3, 4);
    for (int i = 0; i < 2 * FFT_B; i++) sendb(rnd16(), rnd16());
    b_in_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("b_all_outputs_seen", expb_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fft_power_avg.md
Name: fft_power_avg

Overview:
- Sits directly downstream of the FFT core and consumes its complex output stream, one bin per beat in natural order 0..FFT_SIZE-1.
- Computes the power per bin as |X|^2 = re^2 + im^2.
- Averages the power over 2^LOG2_NUM_AVG consecutive frames and emits one averaged power spectrum, tagged with bin index and last flag, over a valid/ready interface to the host/DMA side.

Parameters:
FFT_SIZE, 1024, bins per frame; power of two, >= 4
DATA_WIDTH, 16, signed width of re and im
LOG2_NUM_AVG, 2, log2 of frames averaged; 0 = pass-through power
OUT_WIDTH, 2*DATA_WIDTH, unsigned width of power output

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset, asynchronous, active-low
in_valid_i  in  1  FFT sample valid
in_data_i  in  2*DATA_WIDTH  {re, im}; re in upper half, both signed
in_ready_o  out  1  block accepts in_data_i
out_valid_o  out  1  averaged power valid
out_data_o  out  OUT_WIDTH  averaged power, unsigned
out_bin_o  out  $clog2(FFT_SIZE)  bin index of out_data_o
out_last_o  out  1  high with the bin FFT_SIZE-1 beat
out_ready_i  in  1  downstream accepts output
frame_done_o  out  1  one-cycle pulse when the last bin of an averaged spectrum is popped

Behaviour:
- Accept happens when in_valid_i && in_ready_o. Output transfer happens when out_valid_o && out_ready_i.
- Reset values: in_ready_o=1, out_valid_o=0, out_data_o=0, out_bin_o=0, out_last_o=0, frame_done_o=0. All counters, state and FIFO are cleared. Accumulator contents are don't-care.
- Power arithmetic:
  - Signed squares summed into an unsigned OUT_WIDTH value.
  - Max is (-2^(DW-1))^2 * 2 = 2^(2DW-1), which fits, so there is no saturation.
  - Accumulator width ACC_W = OUT_WIDTH + LOG2_NUM_AVG.
  - Output = (acc + power) >> LOG2_NUM_AVG, truncating; the result always fits OUT_WIDTH.
- Counters:
  - bin_cnt increments per accept and wraps FFT_SIZE-1 -> 0.
  - frame_cnt increments on each bin wrap.
- FSM states: FILL, ACCUM, EMIT.
  - FILL (frame_cnt==0): acc[bin] <= power; the old value is ignored.
  - ACCUM (0 < frame_cnt < 2^L - 1): acc[bin] <= acc[bin] + power.
  - EMIT (frame_cnt == 2^L - 1): push (acc[bin]+power)>>L into the output FIFO; acc is not written.
  - Transition on bin wrap: FILL->ACCUM, ACCUM->ACCUM or EMIT, EMIT->FILL.
  - If 2^L==2, FILL->EMIT directly.
  - If L==0, the FSM stays in EMIT permanently.
- Pipeline:
  - Cycle t (accept): square and register power and bin; issue the accumulator read for that bin.
  - Cycle t+1 (s1): the registered read data arrives; add, then write back or push to the FIFO.
  - No RAW hazard, because the same bin recurs only after FFT_SIZE >= 4 accepts.
  - Latency from accept to out_valid_o is 2 cycles with an empty FIFO.
- Output FIFO: depth 2.
  - In EMIT: in_ready_o = (occ + s1_push - pop) < 2, where s1_push is "s1 holds an EMIT beat" and pop = out_valid_o && out_ready_i. This gives full throughput with out_ready_i held high.
  - In FILL/ACCUM: in_ready_o=1. The FIFO may still be draining the previous spectrum during FILL; this is legal.
- out_last_o and frame_done_o: out_last_o = (out_bin_o == FFT_SIZE-1). frame_done_o pulses on the pop of the last-flagged beat.
- Simultaneous push and pop on a full FIFO cannot occur, because the credit rule prevents it. Push and pop in the same cycle with occ=1 leaves occ=1.
- in_valid_i low: the pipeline bubbles and there is no state change.
- Reset mid-frame: averaging restarts at FILL, bin 0. Partially emitted spectra are dropped and the FIFO is emptied.

Decomposition:
- Package fft_pkg holds:
  - typedef complex_t {re, im};
  - typedef pavg_state_e {FILL, ACCUM, EMIT};
  - function power(complex_t) returning OUT_WIDTH.
- Accumulator storage reuses prim_ram (registered read, 1 cycle), depth FFT_SIZE, width ACC_W.
- One new sub-module: pavg_out_fifo, a 2-entry valid/ready FIFO carrying {data, bin, last}.

Test Plan:
- 4 frames, every bin re=100, im=0, out_ready_i=1 -> 1024 outputs of 10000, bins 0..1023, out_last_o and frame_done_o on bin 1023 only; no output during frames 0-2.
- Frames with re=1,2,3,4 (im=0) on all bins -> (1+4+9+16)>>2 = 7 on every bin (truncation check).
- re=im=-32768 for 4 frames -> output 0x80000000, no wrap.
- Random out_ready_i (50%) in EMIT with continuous in_valid_i -> in_ready_o throttles, no loss or duplication, occ never exceeds 2, bin order preserved.
- rst_ni asserted at bin 500 of frame 2, then 4 clean frames of re=3 -> outputs all 9, first output bin 0, frame_done_o once.
- LOG2_NUM_AVG=0, re=3, im=4 -> output 25 on every frame, 2-cycle latency per bin.
